// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_control_sequencer
//  Description : SAP-1e control unit. Walks a T-state counter through fetch
//                and execute micro-steps and decodes the opcode into the
//                load-enable / bus-drive strobes of the datapath registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap1_control_sequencer #(
    parameter bit HALT_ON_UNDEFINED = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_in,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic [2:0] step,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [2:0] c_T0 = 3'd0;
    localparam logic [2:0] c_T1 = 3'd1;
    localparam logic [2:0] c_T2 = 3'd2;
    localparam logic [2:0] c_T3 = 3'd3;
    localparam logic [2:0] c_T4 = 3'd4;

    localparam logic [3:0] c_OP_LDA = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_STA = 4'b0100;
    localparam logic [3:0] c_OP_LDI = 4'b0101;
    localparam logic [3:0] c_OP_JMP = 4'b0110;
    localparam logic [3:0] c_OP_JC  = 4'b0111;
    localparam logic [3:0] c_OP_JZ  = 4'b1000;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    logic [2:0]  r_step;
    logic        r_halted;

    logic        w_active;
    logic        w_undef;
    logic        w_is_hlt;
    logic        w_last;
    logic [14:0] w_strb;

    // Strobe vector bit positions, fetch/execute decode fills these in.
    localparam int c_PC_INC = 14, c_PC_OUT = 13, c_PC_IN = 12, c_MAR_IN = 11;
    localparam int c_RAM_OUT = 10, c_RAM_IN = 9, c_IR_IN = 8, c_IR_OUT = 7;
    localparam int c_A_IN = 6, c_A_OUT = 5, c_B_IN = 4, c_ALU_OUT = 3;
    localparam int c_ALU_SUB = 2, c_FLAGS_IN = 1, c_OUT_IN = 0;

    // Strobes only escape when the sequencer is actually stepping.
    assign w_active = run & ~r_halted & ~reset;

    // Classify the opcode: undefined codes may optionally halt like HLT.
    always_comb begin
        case (opcode)
            c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA, c_OP_LDI,
            c_OP_JMP, c_OP_JC, c_OP_JZ, c_OP_OUT, c_OP_HLT: w_undef = 1'b0;
            default:                                         w_undef = 1'b1;
        endcase
        w_is_hlt = (opcode == c_OP_HLT) | (w_undef & HALT_ON_UNDEFINED);
    end

    // Micro-step decode of {step, opcode, flags}; opcode ignored in T0/T1.
    always_comb begin
        w_strb = '0;
        w_last = 1'b0;
        case (r_step)
            c_T0: begin
                w_strb[c_PC_OUT] = 1'b1;
                w_strb[c_MAR_IN] = 1'b1;
            end
            c_T1: begin
                w_strb[c_RAM_OUT] = 1'b1;
                w_strb[c_IR_IN]   = 1'b1;
                w_strb[c_PC_INC]  = 1'b1;
            end
            c_T2: begin
                case (opcode)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                        w_strb[c_IR_OUT] = 1'b1;
                        w_strb[c_MAR_IN] = 1'b1;
                    end
                    c_OP_LDI: begin
                        w_strb[c_IR_OUT] = 1'b1;
                        w_strb[c_A_IN]   = 1'b1;
                        w_last           = 1'b1;
                    end
                    c_OP_JMP: begin
                        w_strb[c_IR_OUT] = 1'b1;
                        w_strb[c_PC_IN]  = 1'b1;
                        w_last           = 1'b1;
                    end
                    c_OP_JC: begin
                        w_strb[c_IR_OUT] = carry_flag;
                        w_strb[c_PC_IN]  = carry_flag;
                        w_last           = 1'b1;
                    end
                    c_OP_JZ: begin
                        w_strb[c_IR_OUT] = zero_flag;
                        w_strb[c_PC_IN]  = zero_flag;
                        w_last           = 1'b1;
                    end
                    c_OP_OUT: begin
                        w_strb[c_A_OUT]  = 1'b1;
                        w_strb[c_OUT_IN] = 1'b1;
                        w_last           = 1'b1;
                    end
                    // HLT and undefined codes: silent last step
                    default: w_last = 1'b1;
                endcase
            end
            c_T3: begin
                case (opcode)
                    c_OP_LDA: begin
                        w_strb[c_RAM_OUT] = 1'b1;
                        w_strb[c_A_IN]    = 1'b1;
                        w_last            = 1'b1;
                    end
                    c_OP_ADD, c_OP_SUB: begin
                        w_strb[c_RAM_OUT] = 1'b1;
                        w_strb[c_B_IN]    = 1'b1;
                    end
                    c_OP_STA: begin
                        w_strb[c_A_OUT]  = 1'b1;
                        w_strb[c_RAM_IN] = 1'b1;
                        w_last           = 1'b1;
                    end
                    // IR cannot change mid-instruction; recover to T0 anyway
                    default: w_last = 1'b1;
                endcase
            end
            c_T4: begin
                if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
                    w_strb[c_ALU_OUT]  = 1'b1;
                    w_strb[c_A_IN]     = 1'b1;
                    w_strb[c_FLAGS_IN] = 1'b1;
                    w_strb[c_ALU_SUB]  = (opcode == c_OP_SUB);
                end
                w_last = 1'b1;
            end
            default: w_last = 1'b0;
        endcase
    end

    // T-state counter and halt latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step   <= c_T0;
            r_halted <= 1'b0;
        end else if (r_step > c_T4) begin
            r_step <= c_T0;
        end else if (r_halted) begin
            r_step <= c_T0;
        end else if (run) begin
            if (w_last) begin
                r_step   <= c_T0;
                r_halted <= (r_step == c_T2) & w_is_hlt;
            end else begin
                r_step <= r_step + 3'd1;
            end
        end
    end

    assign {pc_inc, pc_out, pc_in, mar_in, ram_out, ram_in, ir_in, ir_out,
            a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in}
           = w_active ? w_strb : 15'd0;
    assign instr_done = w_active & w_last;
    assign halted     = r_halted & ~reset;
    assign step       = r_step;

endmodule
`default_nettype wire

// File: tb/tb_sap1_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap1_control_sequencer
//  Description : Self-checking bench for sap1_control_sequencer. Two DUTs
//                (HALT_ON_UNDEFINED = 0 and 1) share stimulus and are compared
//                against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap1_control_sequencer;

    // Strobe vector order: pc_inc pc_out pc_in mar_in ram_out ram_in ir_in
    // ir_out a_in a_out b_in alu_out alu_sub flags_in out_in
    localparam logic [14:0] M_PC_INC   = 15'd1 << 14;
    localparam logic [14:0] M_PC_OUT   = 15'd1 << 13;
    localparam logic [14:0] M_PC_IN    = 15'd1 << 12;
    localparam logic [14:0] M_MAR_IN   = 15'd1 << 11;
    localparam logic [14:0] M_RAM_OUT  = 15'd1 << 10;
    localparam logic [14:0] M_RAM_IN   = 15'd1 << 9;
    localparam logic [14:0] M_IR_IN    = 15'd1 << 8;
    localparam logic [14:0] M_IR_OUT   = 15'd1 << 7;
    localparam logic [14:0] M_A_IN     = 15'd1 << 6;
    localparam logic [14:0] M_A_OUT    = 15'd1 << 5;
    localparam logic [14:0] M_B_IN     = 15'd1 << 4;
    localparam logic [14:0] M_ALU_OUT  = 15'd1 << 3;
    localparam logic [14:0] M_ALU_SUB  = 15'd1 << 2;
    localparam logic [14:0] M_FLAGS_IN = 15'd1 << 1;
    localparam logic [14:0] M_OUT_IN   = 15'd1 << 0;
    localparam logic [14:0] M_BUS      = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;

    logic [14:0] s0, s1;
    logic [2:0]  st0, st1;
    logic        dn0, dn1, hl0, hl1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per DUT: position within instruction, halt flag
    int m_step [2];
    bit m_halt [2];

    always #5 clock = ~clock;

    sap1_control_sequencer #(.HALT_ON_UNDEFINED(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_inc(s0[14]), .pc_out(s0[13]), .pc_in(s0[12]), .mar_in(s0[11]),
        .ram_out(s0[10]), .ram_in(s0[9]), .ir_in(s0[8]), .ir_out(s0[7]),
        .a_in(s0[6]), .a_out(s0[5]), .b_in(s0[4]), .alu_out(s0[3]),
        .alu_sub(s0[2]), .flags_in(s0[1]), .out_in(s0[0]),
        .step(st0), .instr_done(dn0), .halted(hl0)
    );

    sap1_control_sequencer #(.HALT_ON_UNDEFINED(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_inc(s1[14]), .pc_out(s1[13]), .pc_in(s1[12]), .mar_in(s1[11]),
        .ram_out(s1[10]), .ram_in(s1[9]), .ir_in(s1[8]), .ir_out(s1[7]),
        .a_in(s1[6]), .a_out(s1[5]), .b_in(s1[4]), .alu_out(s1[3]),
        .alu_sub(s1[2]), .flags_in(s1[1]), .out_in(s1[0]),
        .step(st1), .instr_done(dn1), .halted(hl1)
    );

    // ---------------- reference model ----------------
    function automatic bit m_undefined(input logic [3:0] op);
        return !(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15});
    endfunction

    // Number of clock cycles the instruction occupies
    function automatic int m_len(input logic [3:0] op);
        case (op)
            4'd0, 4'd4: return 4;
            4'd1, 4'd2: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic bit m_is_halt(input logic [3:0] op, input int d);
        return (op == 4'd15) || (d == 1 && m_undefined(op));
    endfunction

    // Strobes for cycle t of instruction op
    function automatic logic [14:0] m_strobes(input logic [3:0] op, input int t,
                                              input logic c, input logic z);
        if (t == 0) return M_PC_OUT | M_MAR_IN;
        if (t == 1) return M_RAM_OUT | M_IR_IN | M_PC_INC;
        case (op)
            4'd0: return (t == 2) ? (M_IR_OUT | M_MAR_IN) : (M_RAM_OUT | M_A_IN);
            4'd1, 4'd2: begin
                if (t == 2) return M_IR_OUT | M_MAR_IN;
                if (t == 3) return M_RAM_OUT | M_B_IN;
                return M_ALU_OUT | M_A_IN | M_FLAGS_IN | ((op == 4'd2) ? M_ALU_SUB : 15'd0);
            end
            4'd4:  return (t == 2) ? (M_IR_OUT | M_MAR_IN) : (M_A_OUT | M_RAM_IN);
            4'd5:  return M_IR_OUT | M_A_IN;
            4'd6:  return M_IR_OUT | M_PC_IN;
            4'd7:  return c ? (M_IR_OUT | M_PC_IN) : 15'd0;
            4'd8:  return z ? (M_IR_OUT | M_PC_IN) : 15'd0;
            4'd14: return M_A_OUT | M_OUT_IN;
            default: return 15'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare both DUTs to the model, advance model
    task automatic cycle(input logic rst, input logic rn, input logic [3:0] op,
                         input logic c, input logic z);
        logic [14:0] act_s, exp_s;
        logic [2:0]  act_st;
        logic        act_dn, act_hl, active;
        reset = rst; run = rn; opcode = op; carry_flag = c; zero_flag = z;
        #1;
        for (int d = 0; d < 2; d++) begin
            act_s  = (d == 0) ? s0 : s1;
            act_st = (d == 0) ? st0 : st1;
            act_dn = (d == 0) ? dn0 : dn1;
            act_hl = (d == 0) ? hl0 : hl1;
            active = rn && !rst && !m_halt[d];
            exp_s  = active ? m_strobes(op, m_step[d], c, z) : 15'd0;
            check($sformatf("d%0d.strobes", d), {17'd0, act_s}, {17'd0, exp_s});
            check($sformatf("d%0d.step", d), {29'd0, act_st}, m_step[d]);
            check($sformatf("d%0d.done", d), {31'd0, act_dn},
                  {31'd0, active && (m_step[d] == m_len(op) - 1)});
            check($sformatf("d%0d.halted", d), {31'd0, act_hl}, {31'd0, m_halt[d] && !rst});
            check($sformatf("d%0d.bus1hot", d), {31'd0, $onehot0(act_s & M_BUS)}, 32'd1);
        end
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_step[d] = 0;
                m_halt[d] = 0;
            end else if (!m_halt[d] && rn) begin
                if (m_step[d] == m_len(op) - 1) begin
                    m_step[d] = 0;
                    if (m_is_halt(op, d)) m_halt[d] = 1;
                end else begin
                    m_step[d]++;
                end
            end
        end
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        for (int i = 0; i < m_len(op); i++) cycle(1'b0, 1'b1, op, c, z);
    endtask

    initial begin
        logic [3:0] rop;
        // Bring both DUTs to a known state before the model starts tracking
        reset = 1'b1; run = 1'b0; opcode = 4'd0; carry_flag = 1'b0; zero_flag = 1'b0;
        @(posedge clock); #1;
        m_step[0] = 0; m_step[1] = 0; m_halt[0] = 0; m_halt[1] = 0;
        cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);     // reset held: all outputs quiet

        run_instr(4'd5, 1'b0, 1'b0);             // LDI
        run_instr(4'd2, 1'b1, 1'b1);             // SUB
        run_instr(4'd7, 1'b0, 1'b1);             // JC not taken
        run_instr(4'd7, 1'b1, 1'b0);             // JC taken
        run_instr(4'd8, 1'b1, 1'b0);             // JZ not taken
        run_instr(4'd8, 1'b0, 1'b1);             // JZ taken
        run_instr(4'd0, 1'b0, 1'b0);             // LDA
        run_instr(4'd4, 1'b0, 1'b0);             // STA
        run_instr(4'd14, 1'b0, 1'b0);            // OUT
        run_instr(4'd6, 1'b0, 1'b0);             // JMP

        // ADD with a 4-cycle run=0 pause while at T3
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);

        // Undefined opcode: NOP on DUT0, halts DUT1
        run_instr(4'd10, 1'b0, 1'b0);
        run_instr(4'd10, 1'b0, 1'b0);

        // HLT, then 20 cycles of toggling run, then a one-cycle reset
        run_instr(4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, i[0], 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        run_instr(4'd5, 1'b0, 1'b0);

        // Random opcode stream; IR only changes between instructions
        rop = 4'd5;
        for (int i = 0; i < 1500; i++) begin
            if ((m_halt[0] || m_step[0] == 0) && (m_halt[1] || m_step[1] == 0))
                rop = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85), rop,
                  1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Control unit for the SAP-1e datapath.
- Steps a T-state counter through fetch and execute micro-steps, and decodes the instruction register opcode into the load-enable and bus-drive strobes for the PC, MAR, RAM, IR, A, B, ALU, flags and output registers.
- Each strobe drives the data_in_en (or bus output enable) of exactly one datapath register.
- Instructions are variable length. The block halts on HLT until reset.

Parameters:
- HALT_ON_UNDEFINED, 0: 1 = an undefined opcode halts like HLT; 0 = an undefined opcode executes as a NOP.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; returns the sequencer to T0, not halted
- run  input  1  step enable; low freezes the state and masks all strobes
- opcode  input  4  IR[7:4]
- carry_flag  input  1  flags register C
- zero_flag  input  1  flags register Z
- pc_inc  output  1  PC count enable
- pc_out  output  1  PC drives bus
- pc_in  output  1  PC load from bus
- mar_in  output  1  MAR load
- ram_out  output  1  RAM drives bus
- ram_in  output  1  RAM write
- ir_in  output  1  IR load
- ir_out  output  1  IR[3:0] drives bus
- a_in  output  1  A load
- a_out  output  1  A drives bus
- b_in  output  1  B load
- alu_out  output  1  ALU drives bus
- alu_sub  output  1  ALU subtract select
- flags_in  output  1  flags register load
- out_in  output  1  output register load
- step  output  3  current T-state, 0..4
- instr_done  output  1  high during the last micro-step of an instruction
- halted  output  1  high while in HALT

Behaviour:
- State register: step (T0..T4) plus a halted bit. Both are updated only on the rising clock edge.
- Synchronous reset: step=0, halted=0. While reset=1, all strobes, instr_done and halted read 0.
- Strobes are a combinational decode of {step, opcode, flags}. They are valid for the whole cycle, and the datapath captures at the next edge.
- Strobes are forced to 0 when run=0, halted=1 or reset=1.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) may be high in any cycle.
- opcode is ignored during T0 and T1, because the IR still holds the previous instruction.
- Fetch, all instructions:
  - T0: pc_out, mar_in
  - T1: ram_out, ir_in, pc_inc
- Execute sequences:
  - LDA 0000: T2 ir_out, mar_in; T3 ram_out, a_in (last)
  - ADD 0001: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flags_in (last)
  - SUB 0010: as ADD, with alu_sub high in T4 only
  - STA 0100: T2 ir_out, mar_in; T3 a_out, ram_in (last)
  - LDI 0101: T2 ir_out, a_in (last)
  - JMP 0110: T2 ir_out, pc_in (last)
  - JC 0111: T2 ir_out and pc_in only if carry_flag=1, otherwise no strobes (last)
  - JZ 1000: as JC, using zero_flag
  - OUT 1110: T2 a_out, out_in (last)
  - HLT 1111: T2 has no strobes. Next edge sets halted=1 and step=0.
  - Undefined opcode: T2 has no strobes (last). If HALT_ON_UNDEFINED=1, it behaves as HLT.
- instr_done:
  - High in the last step of each instruction. The next edge (with run=1) takes step to 0.
  - Also high in the HLT T2 step.
- Instruction cycle counts: LDI/JMP/JC/JZ/OUT/undefined = 3, LDA/STA = 4, ADD/SUB = 5.
- T4 is reached only by ADD/SUB. Step values 5..7 are unreachable; if seen, the next edge forces step=0.
- Halted:
  - step holds at 0 and all strobes are 0; run is ignored.
  - Only reset clears halted.
- run=0 mid-instruction:
  - step and halted hold and all strobes are 0.
  - Execution resumes at the same step when run returns to 1. No micro-step is lost or repeated.
- Reset mid-instruction: takes effect at the next edge regardless of step, run or halted.
- JC/JZ sample the flags combinationally in T2. The flags register is written only in ADD/SUB T4, so the flags are stable during T2.

Test Plan:
- Reset, then run=1 with opcode=0101 (LDI) → T0 {pc_out, mar_in}; T1 {ram_out, ir_in, pc_inc}; T2 {ir_out, a_in, instr_done}; step sequence 0,1,2,0.
- opcode=0010 (SUB) → step sequence 0,1,2,3,4,0. T4 shows alu_out, a_in, flags_in, alu_sub=1, and alu_sub is 0 in all other steps. instr_done is high only in T4.
- opcode=0111 (JC):
  - carry_flag=0 → no pc_in in T2, 3-cycle instruction.
  - carry_flag=1 → ir_out and pc_in in T2.
  - Repeat with JZ/zero_flag.
- opcode=1111 (HLT) → halted=1 after the T2 edge. All strobes stay 0 for 20 cycles with run toggling. reset=1 for one cycle → halted=0, step=0, and T0 strobes follow.
- ADD, with run dropped to 0 at step=3 for 4 cycles → step stays 3 and strobes are 0. After run=1, T3 {ram_out, b_in} appears exactly once, then T4.
- Every cycle of a random opcode stream → the bus-driver one-hot-or-zero assertion holds.
- opcode=1010 → NOP, 3 cycles, with HALT_ON_UNDEFINED=0. The same opcode with HALT_ON_UNDEFINED=1 → halted=1.
